clk_ctrl: RTL and testbench
===========================

# clk_ctrl

Run-control and clock-enable scheduler for the FPGA test harness of the RISC-V core. It sits between the board-level command source (buttons/UART decoder) and the core, and generates a single-cycle clock-enable `ce` every `div` cycles of `clk`. The enable stream can be started, halted, single- or multi-stepped, and re-divided at run time without glitches. All downstream logic runs on `clk` and qualifies with `ce`; no derived clock is produced.

## Interface
- `DIV_W`, 8: width of divide ratio and step-count argument
- `DEFAULT_DIV`, 4: divide ratio after reset (must be ≥1)
- `CNT_W`, 32: width of enable-pulse counter

- `clk`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted; transfer when `cmd_valid & cmd_ready` at posedge
- `cmd_op`  in  2  00 SETDIV, 01 RUN, 10 HALT, 11 STEP
- `cmd_arg`  in  DIV_W  SETDIV: new ratio; STEP: pulse count; ignored otherwise
- `ce`  out  1  clock-enable pulse for the core
- `state`  out  2  00 HALT, 01 RUN, 10 STEP
- `busy`  out  1  `state != HALT`
- `div_cur`  out  DIV_W  ratio currently in effect
- `cycles`  out  CNT_W  count of `ce` pulses since reset, wraps modulo 2^CNT_W

## Operation
- Registers: `state`, phase counter `ph` (0..div_cur-1), `div_cur`, `div_pend` + `pend_v`, `step_left`, `cycles`.
- `ce = busy && (ph == div_cur-1)`; decoded from registers only, no input-to-output path.
- `ph` advances every cycle while busy, wraps to 0 after `div_cur-1`; held at 0 in HALT.
- Ratio rule: arg 0 clamped to 1; ratio 1 gives `ce` every cycle while busy.
- `cmd_ready = !pend_v`.
- SETDIV in HALT: `div_cur` loaded next cycle; `pend_v` stays 0.
- SETDIV while busy: `div_pend` loaded, `pend_v`=1; applied on the cycle `ph` wraps (the `ce` cycle): `div_cur<=div_pend`, `ph<=0`, `pend_v<=0`. The current period always completes at the old ratio.
- RUN: from HALT → RUN, `ph<=0`. From RUN: no effect. From STEP → RUN, `ph` continues.
- HALT: from any state → HALT next cycle, `ph<=0`, `step_left<=0`; any pending SETDIV is applied immediately. If accepted on a `ce` cycle, that `ce` still occurs.
- STEP: `step_left<=max(arg,1)`, state → STEP. From HALT `ph<=0`; from RUN/STEP `ph` continues. A `ce` in the accept cycle is not counted against the new step count.
- In STEP, each `ce` decrements `step_left`. On the `ce` with `step_left==1`: → HALT, `ph<=0`.
- `cycles` increments on every `ce`.
- Transitions: HALT→RUN (RUN), HALT→STEP (STEP), RUN→HALT (HALT), RUN→STEP (STEP), STEP→HALT (HALT or last step), STEP→RUN (RUN), STEP→STEP (STEP reloads count).

## Timing
- Reset (sync, priority over commands): `state`=HALT, `ph`=0, `div_cur`=DEFAULT_DIV, `pend_v`=0, `step_left`=0, `cycles`=0. Outputs: `ce`=0, `busy`=0, `cmd_ready`=1.
- Reset mid-RUN/STEP: `ce` is 0 in the cycle after the reset edge, and any pending ratio is discarded.
- RUN accepted at edge t from HALT: `busy`=1 from t+1; first `ce` in cycle t+div_cur, then every div_cur cycles.
- STEP n from HALT at edge t: `ce` in cycles t+k·div for k=1..n; `busy` falls the cycle after the n-th `ce`.
- SETDIV while busy: `cmd_ready` is low from the cycle after acceptance through the wrap cycle, and high again the cycle after.
- `ce` never shorter or longer than 1 cycle, and no two `ce` closer than min(old,new) div cycles.

## Test plan
- Reset, then RUN with DEFAULT_DIV=4 → `ce` at cycles 4, 8, 12 after acceptance, `cycles`=3 after 12; `state`=01.
- HALT, SETDIV 0 → `div_cur`=1; STEP 3 → exactly 3 consecutive `ce` cycles, then `state`=00, `busy`=0.
- RUN at div 4, SETDIV 2 two cycles after a `ce` → `cmd_ready` low until the next `ce` (old spacing 4), then `ce` spacing 2, `cmd_ready` high.
- STEP 5 at div 3, HALT after 2nd `ce` → no further `ce`, `cycles`=2, `step_left` cleared; new STEP 1 gives 1 `ce` 3 cycles later.
- RUN, assert `rst` for 1 cycle with SETDIV pending and cmd_valid=1 → all reset values, `div_cur`=4, command dropped.
- `cycles` preloaded near wrap via small CNT_W=4 build: 17 `ce` pulses → `cycles`=1.

Source files
------------

// File: rtl/clk_ctrl.sv
// rtl/clk_ctrl.sv - run-control and clock-enable scheduler for the core test harness
module clk_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_arg,
    output logic             ce,
    output logic [1:0]       state,
    output logic             busy,
    output logic [DIV_W-1:0] div_cur,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [1:0] OP_SETDIV = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    state_t           st, st_n;
    logic [DIV_W-1:0] ph, ph_n;
    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] div_pend, div_pend_n;
    logic             pend_v, pend_v_n;
    logic [DIV_W-1:0] step_left, step_left_n;
    logic [CNT_W-1:0] cycles_n;
    logic [DIV_W-1:0] arg_c;
    logic             acc;
    logic             last_step;

    assign busy      = (st != ST_HALT);
    assign ce        = busy && (ph == div_cur - 1'b1);
    assign cmd_ready = !pend_v;
    assign state     = st;
    assign acc       = cmd_valid && cmd_ready;
    assign arg_c     = (cmd_arg == '0) ? DIV_W'(1) : cmd_arg;
    assign last_step = (st == ST_STEP) && ce && (step_left == DIV_W'(1));

    always_comb begin
        st_n        = st;
        ph_n        = busy ? (ce ? '0 : ph + 1'b1) : '0;
        div_n       = div_cur;
        div_pend_n  = div_pend;
        pend_v_n    = pend_v;
        step_left_n = step_left;
        cycles_n    = cycles + CNT_W'(ce);

        // A deferred ratio takes effect only at a period boundary so no ce is clipped.
        if (pend_v && ce) begin
            div_n    = div_pend;
            pend_v_n = 1'b0;
        end

        if ((st == ST_STEP) && ce) begin
            if (last_step) begin
                st_n        = ST_HALT;
                step_left_n = '0;
            end else begin
                step_left_n = step_left - 1'b1;
            end
        end

        // Commands override the automatic step bookkeeping above.
        if (acc) begin
            unique case (cmd_op)
                OP_SETDIV: begin
                    if (!busy || last_step) begin
                        div_n = arg_c;
                    end else begin
                        div_pend_n = arg_c;
                        pend_v_n   = 1'b1;
                    end
                end
                OP_RUN: begin
                    if (st == ST_HALT) ph_n = '0;
                    st_n = ST_RUN;
                end
                OP_HALT: begin
                    st_n        = ST_HALT;
                    ph_n        = '0;
                    step_left_n = '0;
                    if (pend_v) begin
                        div_n    = div_pend;
                        pend_v_n = 1'b0;
                    end
                end
                OP_STEP: begin
                    if (st == ST_HALT) ph_n = '0;
                    st_n        = ST_STEP;
                    step_left_n = arg_c;
                end
                default: ;
            endcase
        end

        if (st_n == ST_HALT) ph_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_HALT;
            ph        <= '0;
            div_cur   <= DIV_W'(DEFAULT_DIV);
            div_pend  <= '0;
            pend_v    <= 1'b0;
            step_left <= '0;
            cycles    <= '0;
        end else begin
            st        <= st_n;
            ph        <= ph_n;
            div_cur   <= div_n;
            div_pend  <= div_pend_n;
            pend_v    <= pend_v_n;
            step_left <= step_left_n;
            cycles    <= cycles_n;
        end
    end

endmodule

// File: tb/tb_clk_ctrl.sv
// tb/tb_clk_ctrl.sv - directed self-checking bench for clk_ctrl
module tb_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_arg = 8'd0;
    logic        cmd_ready, ce, busy;
    logic [1:0]  state;
    logic [7:0]  div_cur;
    logic [31:0] cycles;
    logic        cmd_ready4, ce4, busy4;
    logic [1:0]  state4;
    logic [7:0]  div_cur4;
    logic [3:0]  cycles4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ce(ce), .state(state),
        .busy(busy), .div_cur(div_cur), .cycles(cycles)
    );

    clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ce(ce4), .state(state4),
        .busy(busy4), .div_cur(div_cur4), .cycles(cycles4)
    );

    localparam logic [1:0] SETDIV = 2'b00, RUN = 2'b01, HALT = 2'b10, STEP = 2'b11;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cmd_set(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    task automatic ce_next(input int k, input string tag);
        for (int i = 1; i <= k; i++) begin
            nxt();
            chk(tag, 64'(ce), 64'(i == k));
        end
    endtask

    initial begin
        // reset
        nxt(); nxt();
        rst = 1'b0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ce", 64'(ce), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_div", 64'(div_cur), 64'd4);
        chk("rst_cycles", 64'(cycles), 64'd0);

        // RUN at default ratio 4
        cmd_set(RUN, 8'd0);
        ce_next(4, "run_ce1");
        chk("run_state", 64'(state), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        ce_next(4, "run_ce2");
        ce_next(4, "run_ce3");
        chk("run_cycles_pre", 64'(cycles), 64'd2);
        nxt();
        chk("run_cycles3", 64'(cycles), 64'd3);

        // HALT, SETDIV 0 clamps to 1, STEP 3 gives three back-to-back ce
        cmd_set(HALT, 8'd0);
        nxt();
        chk("halt_state", 64'(state), 64'd0);
        chk("halt_ce", 64'(ce), 64'd0);
        cmd_set(SETDIV, 8'd0);
        nxt();
        chk("div_clamp", 64'(div_cur), 64'd1);
        chk("div_ready", 64'(cmd_ready), 64'd1);
        cmd_set(STEP, 8'd3);
        ce_next(1, "step1_a");
        chk("step_state", 64'(state), 64'd2);
        ce_next(1, "step1_b");
        ce_next(1, "step1_c");
        nxt();
        chk("step_done_ce", 64'(ce), 64'd0);
        chk("step_done_state", 64'(state), 64'd0);
        chk("step_done_busy", 64'(busy), 64'd0);
        chk("step_cycles", 64'(cycles), 64'd6);

        // SETDIV 2 while running at 4, issued two cycles after a ce
        cmd_set(SETDIV, 8'd4);
        nxt();
        chk("div4", 64'(div_cur), 64'd4);
        cmd_set(RUN, 8'd0);
        ce_next(4, "rd_ce0");
        nxt(); nxt();
        cmd_set(SETDIV, 8'd2);
        nxt();
        chk("pend_ready_lo", 64'(cmd_ready), 64'd0);
        chk("pend_ce_lo", 64'(ce), 64'd0);
        nxt();
        chk("pend_ce_old", 64'(ce), 64'd1);
        chk("pend_ready_wrap", 64'(cmd_ready), 64'd0);
        chk("pend_div_old", 64'(div_cur), 64'd4);
        ce_next(2, "new_ce1");
        chk("pend_div_new", 64'(div_cur), 64'd2);
        chk("pend_ready_hi", 64'(cmd_ready), 64'd1);
        ce_next(2, "new_ce2");
        chk("pend_cycles", 64'(cycles), 64'd9);

        // STEP 5 at ratio 3, HALT on the 2nd ce
        cmd_set(HALT, 8'd0);
        nxt();
        cmd_set(SETDIV, 8'd3);
        nxt();
        chk("div3", 64'(div_cur), 64'd3);
        chk("s5_cycles0", 64'(cycles), 64'd10);
        cmd_set(STEP, 8'd5);
        ce_next(3, "s5_ce1");
        ce_next(3, "s5_ce2");
        cmd_set(HALT, 8'd0);
        nxt();
        chk("s5_halt_state", 64'(state), 64'd0);
        chk("s5_cycles", 64'(cycles), 64'd12);
        for (int i = 0; i < 8; i++) begin
            chk("s5_no_ce", 64'(ce), 64'd0);
            nxt();
        end
        cmd_set(STEP, 8'd1);
        ce_next(3, "s1_ce");
        nxt();
        chk("s1_state", 64'(state), 64'd0);
        chk("s1_cycles", 64'(cycles), 64'd13);

        // reset mid-RUN with a pending ratio and a command presented
        cmd_set(SETDIV, 8'd6);
        nxt();
        cmd_set(RUN, 8'd0);
        nxt();
        cmd_set(SETDIV, 8'd7);
        nxt();
        chk("mid_pend", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = SETDIV; cmd_arg = 8'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("mr_ce", 64'(ce), 64'd0);
        chk("mr_state", 64'(state), 64'd0);
        chk("mr_ready", 64'(cmd_ready), 64'd1);
        chk("mr_div", 64'(div_cur), 64'd4);
        chk("mr_cycles", 64'(cycles), 64'd0);
        for (int i = 0; i < 10; i++) nxt();
        chk("mr_div_later", 64'(div_cur), 64'd4);

        // 17 pulses at ratio 1: narrow counter wraps to 1
        cmd_set(SETDIV, 8'd1);
        nxt();
        cmd_set(RUN, 8'd0);
        for (int i = 0; i < 17; i++) ce_next(1, "wrap_ce");
        cmd_set(HALT, 8'd0);
        nxt();
        chk("wrap_ce_off", 64'(ce), 64'd0);
        chk("wrap_cycles32", 64'(cycles), 64'd17);
        chk("wrap_cycles4", 64'(cycles4), 64'd1);

        // RUN -> STEP keeps the phase, counts only later ce
        cmd_set(SETDIV, 8'd2);
        nxt();
        cmd_set(RUN, 8'd0);
        ce_next(2, "rs_ce0");
        nxt();
        cmd_set(STEP, 8'd2);
        nxt();
        chk("rs_ce1", 64'(ce), 64'd1);
        chk("rs_state", 64'(state), 64'd2);
        ce_next(2, "rs_ce2");
        chk("rs_state_last", 64'(state), 64'd2);
        nxt();
        chk("rs_halted", 64'(state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
